// File: rtl/plru_set_controller.sv
// rtl/plru_set_controller.sv - per-set tree pseudo-LRU controller, serialised touch/victim ops.
// Optional macro PLRU_INVALID_FIRST_EN: victim picks the lowest invalid way before the tree walk.
module plru_set_controller #(
  parameter int ASSOCIATIVITY = 8,
  parameter int SETS          = 64,
  localparam int WAY_W = $clog2(ASSOCIATIVITY),
  localparam int SET_W = $clog2(SETS),
  localparam int NODES = ASSOCIATIVITY - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             resp_valid,
  output logic [WAY_W-1:0] resp_way
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_UPDATE} state_t;

  state_t             state_q, state_d;
  logic               op_q;
  logic [SET_W-1:0]   set_q;
  logic [WAY_W-1:0]   way_q;
  logic [WAY_W-1:0]   resp_way_q;
  logic [NODES-1:0]   bits_q;
  logic [NODES-1:0]   plru_q [SETS];
  logic [WAY_W-1:0]   victim_way;
  logic [NODES-1:0]   bits_upd;

  // Heap-ordered walk: node bit 0 steers toward the right subtree (way bit 1).
  function automatic logic [WAY_W-1:0] tree_victim(input logic [NODES-1:0] b);
    logic [WAY_W-1:0] w;
    logic [NODES-1:0] sh;
    int node;
    w    = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      sh = b >> node;
      if (!sh[0]) begin
        w    = w | (WAY_W'(1) << (WAY_W - 1 - lvl));
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
    end
    return w;
  endfunction

  function automatic logic [NODES-1:0] tree_touch(input logic [NODES-1:0] b,
                                                  input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    logic [WAY_W-1:0] wsh;
    int node;
    r    = b;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      wsh = w >> (WAY_W - 1 - lvl);
      if (wsh[0]) begin
        r    = r | (NODES'(1) << node);
        node = 2 * node + 2;
      end else begin
        r    = r & ~(NODES'(1) << node);
        node = 2 * node + 1;
      end
    end
    return r;
  endfunction

`ifdef PLRU_INVALID_FIRST_EN
  logic [ASSOCIATIVITY-1:0] valid_q [SETS];
  logic [ASSOCIATIVITY-1:0] vset;
  logic [ASSOCIATIVITY-1:0] vsh;

  always_comb begin
    vset       = valid_q[set_q];
    victim_way = tree_victim(plru_q[set_q]);
    vsh        = '0;
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      vsh = vset >> i;
      if (!vsh[0]) victim_way = WAY_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: '0};
    end else if (state_q == ST_UPDATE) begin
      valid_q[set_q][way_q] <= 1'b1;
    end
  end
`else
  always_comb begin
    victim_way = tree_victim(plru_q[set_q]);
  end
`endif

  always_comb begin
    bits_upd = tree_touch(bits_q, way_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = !rst && (state_q == ST_IDLE);
    resp_valid = !rst && (state_q == ST_UPDATE);
    resp_way   = rst ? '0 : resp_way_q;
  end

  // Reset in LOOKUP/UPDATE drops the op before its write, so no stale update survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 1'b0;
      set_q      <= '0;
      way_q      <= '0;
      bits_q     <= '0;
      resp_way_q <= '0;
      plru_q     <= '{default: '0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            set_q <= req_set;
            way_q <= req_way;
          end
        end
        ST_LOOKUP: begin
          bits_q <= plru_q[set_q];
          if (op_q) way_q <= victim_way;
          resp_way_q <= op_q ? victim_way : way_q;
        end
        ST_UPDATE: begin
          plru_q[set_q] <= bits_upd;
        end
        default: ;
      endcase
    end
  end

endmodule
